pll_lock_sequencer: RTL and testbench

Power-up and lock supervisor for the static ProASIC3 PLL core that generates the GLA/GLB/GLC fabric clocks. The block runs on the free-running 50 MHz PLL input clock and drives the PLL's active-low POWERDOWN pin. It synchronises and qualifies the PLL LOCK output and power-cycles the PLL on lock timeout. It exposes a registered READY that downstream reset generators use to release the GLx clock domains.

---
 rtl/pll_seq_pkg.sv | 24 ++
 rtl/sync2.sv | 27 ++
 rtl/pll_lock_sequencer.sv | 141 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL power-up / lock sequencer.
// State encodings are exported on the debug STATE port, so they are fixed here.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_PWRUP     = 3'd1,
    ST_LOCK_WAIT = 3'd2,
    ST_QUAL      = 3'd3,
    ST_RUN       = 3'd4,
    ST_CYCLE     = 3'd5,
    ST_FAIL      = 3'd6
  } pll_state_e;

  // One shared down-counter must hold the largest cycle parameter.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single-bit asynchronous input.
// RST_VAL selects the value both stages take while reset is held.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up and lock supervisor for a static PLL: drives POWERDOWN, qualifies
// the synchronised LOCK, power-cycles on timeout and reports READY/FAIL.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PWRUP_CYCLES     = 64,
  parameter int LOCK_TIMEOUT     = 4096,
  parameter int LOCK_QUAL_CYCLES = 256,
  parameter int MAX_RETRIES      = 3,
  localparam int RW = $clog2(MAX_RETRIES + 1)
) (
  input  logic          i_clka,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_clr_status,
  input  logic          i_lock,
  output logic          o_powerdown,
  output logic          o_ready,
  output logic          o_fail,
  output logic          o_lock_lost,
  output logic [RW-1:0] o_retry_cnt,
  output logic [2:0]    o_state
);

  localparam int CW = cnt_width(PWRUP_CYCLES, LOCK_TIMEOUT, LOCK_QUAL_CYCLES);
  localparam logic [CW-1:0] PWRUP_LOAD   = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] QUAL_LOAD    = CW'(LOCK_QUAL_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  pll_state_e    r_state;
  pll_state_e    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_load;
  logic [RW-1:0] r_retry;
  logic [RW-1:0] w_retry_next;
  logic          r_powerdown;
  logic          r_ready;
  logic          r_fail;
  logic          r_lock_lost;
  logic          w_lock_s;
  logic          w_cnt_zero;
  logic          w_lost_set;

  sync2 #(
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .i_clk  (i_clka),
    .i_srst (i_rst),
    .i_d    (i_lock),
    .o_q    (w_lock_s)
  );

  assign w_cnt_zero = (r_cnt == '0);
  assign w_lost_set = i_en && (r_state == ST_RUN) && !w_lock_s;

  // EN low overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    w_retry_next = r_retry;
    if (!i_en) begin
      w_state_next = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_next = ST_PWRUP;
          w_retry_next = '0;
        end
        ST_PWRUP: begin
          if (w_cnt_zero) w_state_next = ST_LOCK_WAIT;
        end
        ST_LOCK_WAIT: begin
          if (w_lock_s) begin
            w_state_next = ST_QUAL;
          end else if (w_cnt_zero) begin
            if (r_retry < RETRY_MAX) begin
              w_retry_next = r_retry + RW'(1);
              w_state_next = ST_CYCLE;
            end else begin
              w_state_next = ST_FAIL;
            end
          end
        end
        ST_QUAL: begin
          if (!w_lock_s) w_state_next = ST_LOCK_WAIT;
          else if (w_cnt_zero) w_state_next = ST_RUN;
        end
        ST_RUN: begin
          if (!w_lock_s) w_state_next = ST_LOCK_WAIT;
        end
        ST_CYCLE: begin
          if (w_cnt_zero) w_state_next = ST_PWRUP;
        end
        ST_FAIL: w_state_next = ST_FAIL;
        default: w_state_next = ST_OFF;
      endcase
    end
  end

  always_comb begin
    w_cnt_load = '0;
    case (w_state_next)
      ST_PWRUP, ST_CYCLE: w_cnt_load = PWRUP_LOAD;
      ST_LOCK_WAIT:       w_cnt_load = TIMEOUT_LOAD;
      ST_QUAL:            w_cnt_load = QUAL_LOAD;
      default:            w_cnt_load = '0;
    endcase
  end

  // Outputs are decoded from the next state so they move with STATE.
  always_ff @(posedge i_clka) begin
    if (i_rst) begin
      r_state     <= ST_OFF;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_powerdown <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_retry <= w_retry_next;
      if (w_state_next != r_state) r_cnt <= w_cnt_load;
      else if (!w_cnt_zero)        r_cnt <= r_cnt - 1'b1;
      r_powerdown <= (w_state_next == ST_PWRUP) || (w_state_next == ST_LOCK_WAIT) ||
                     (w_state_next == ST_QUAL)  || (w_state_next == ST_RUN);
      r_ready     <= (w_state_next == ST_RUN);
      r_fail      <= (w_state_next == ST_FAIL);
      if (w_lost_set)        r_lock_lost <= 1'b1;
      else if (i_clr_status) r_lock_lost <= 1'b0;
    end
  end

  assign o_powerdown = r_powerdown;
  assign o_ready     = r_ready;
  assign o_fail      = r_fail;
  assign o_lock_lost = r_lock_lost;
  assign o_retry_cnt = r_retry;
  assign o_state     = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed scenarios plus randomized traffic for pll_lock_sequencer, checked
// every cycle against a behavioural model of the sequencing rules.
module tb_pll_lock_sequencer;

  localparam int P  = 4;
  localparam int T  = 16;
  localparam int Q  = 8;
  localparam int M  = 2;
  localparam int RW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst, en, clr, lock;
  logic          powerdown, ready, fail, lock_lost;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    state;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .PWRUP_CYCLES     (P),
    .LOCK_TIMEOUT     (T),
    .LOCK_QUAL_CYCLES (Q),
    .MAX_RETRIES      (M)
  ) dut (
    .i_clka       (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_clr_status (clr),
    .i_lock       (lock),
    .o_powerdown  (powerdown),
    .o_ready      (ready),
    .o_fail       (fail),
    .o_lock_lost  (lock_lost),
    .o_retry_cnt  (retry_cnt),
    .o_state      (state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: state number, cycles spent in it, retries, sticky flag,
  // and the last two sampled LOCK values (the synchroniser delay).
  int m_state = 0;
  int m_age   = 0;
  int m_retry = 0;
  bit m_lost  = 0;
  bit m_s1    = 0;
  bit m_s2    = 0;

  int seq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_step(input bit e, input bit r, input bit c, input bit l);
    int ns;
    bit ls;
    if (r) begin
      m_state = 0; m_age = 0; m_retry = 0; m_lost = 0; m_s1 = 0; m_s2 = 0;
      return;
    end
    ls = m_s2;
    ns = m_state;
    if (!e) ns = 0;
    else begin
      case (m_state)
        0: begin ns = 1; m_retry = 0; end
        1: if (m_age + 1 >= P) ns = 2;
        2: begin
          if (ls) ns = 3;
          else if (m_age + 1 >= T) begin
            if (m_retry < M) begin m_retry++; ns = 5; end
            else ns = 6;
          end
        end
        3: if (!ls) ns = 2; else if (m_age + 1 >= Q) ns = 4;
        4: if (!ls) ns = 2;
        5: if (m_age + 1 >= P) ns = 1;
        default: ns = m_state;
      endcase
    end
    if (e && m_state == 4 && !ls) m_lost = 1;
    else if (c) m_lost = 0;
    m_age = (ns != m_state) ? 0 : m_age + 1;
    m_state = ns;
    m_s2 = m_s1;
    m_s1 = l;
  endtask

  task automatic compare_model();
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("powerdown", 32'(powerdown), 32'(m_state >= 1 && m_state <= 4));
    check_eq("ready", 32'(ready), 32'(m_state == 4));
    check_eq("fail", 32'(fail), 32'(m_state == 6));
    check_eq("lock_lost", 32'(lock_lost), 32'(m_lost));
    check_eq("retry_cnt", 32'(retry_cnt), 32'(m_retry));
  endtask

  task automatic step(input logic e, input logic r, input logic c, input logic l);
    en = e; rst = r; clr = c; lock = l;
    model_step(e, r, c, l);
    @(negedge clk);
    compare_model();
    if (seq.size() == 0 || seq[$] != int'(state)) seq.push_back(int'(state));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_pd", 32'(powerdown), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    seq.delete();
  endtask

  task automatic steps_until_ready(input string tag, input int budget, input int exp);
    int n;
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (ready) begin n = i; break; end
    end
    check_eq(tag, 32'(n), 32'(exp));
  endtask

  task automatic check_seq(input string tag, input int exp[]);
    check_eq({tag, "_len"}, 32'(seq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check_eq($sformatf("%s%0d", tag, i), (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF_FFFF,
               32'(exp[i]));
  endtask

  initial begin
    int   n, c5, c5_pd, saved_retry;
    logic re, rl;

    // Nominal lock.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("pd_after_en", 32'(powerdown), 32'd1);
    check_eq("pwrup_after_en", 32'(state), 32'd1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    steps_until_ready("nominal_ready_lat", 40, 2 + Q + 1);
    check_eq("nominal_fail", 32'(fail), 32'd0);
    check_eq("nominal_retry", 32'(retry_cnt), 32'd0);

    // Lock loss in RUN, then status clear.
    saved_retry = int'(retry_cnt);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (!ready && lock_lost) begin n = i; break; end
    end
    check_eq("loss_latency", 32'(n), 32'd3);
    check_eq("loss_pd", 32'(powerdown), 32'd1);
    check_eq("loss_retry", 32'(retry_cnt), 32'(saved_retry));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("loss_sticky", 32'(lock_lost), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("loss_cleared", 32'(lock_lost), 32'd0);

    // Glitch during qualification.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    steps_until_ready("glitch_ready_lat", 40, 2 + Q + 1);
    check_seq("glitch_seq", '{1, 2, 3, 2, 3, 4});

    // Timeout, retries and FAIL.
    do_reset();
    c5 = 0; c5_pd = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (state == 3'd5) begin c5++; if (powerdown) c5_pd++; end
      if (state == 3'd6) break;
    end
    check_seq("timeout_seq", '{1, 2, 5, 1, 2, 5, 1, 2, 6});
    check_eq("cycle_len_total", 32'(c5), 32'(2 * P));
    check_eq("cycle_pd_high", 32'(c5_pd), 32'd0);
    check_eq("timeout_retry", 32'(retry_cnt), 32'(M));
    check_eq("timeout_fail", 32'(fail), 32'd1);
    check_eq("timeout_pd", 32'(powerdown), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("fail_holds", 32'(state), 32'd6);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("fail_en_drop", 32'(fail), 32'd0);

    // EN drop at QUAL cycle 3, then reset at QUAL cycle 3.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      n = 0;
      for (int i = 0; i < 40; i++) begin
        step(1'b1, 1'b0, 1'b0, 1'b1);
        if (state == 3'd3) begin n = 1; break; end
      end
      check_eq("reach_qual", 32'(n), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (pass == 0) begin
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("endrop_state", 32'(state), 32'd0);
        check_eq("endrop_pd", 32'(powerdown), 32'd0);
      end else begin
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_pd", 32'(powerdown), 32'd0);
        check_eq("rst_retry", 32'(retry_cnt), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("rst_resume", 32'(state), 32'd1);
        check_eq("rst_resume_pd", 32'(powerdown), 32'd1);
      end
    end

    // Randomized traffic against the model.
    do_reset();
    re = 1'b1; rl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (re && $urandom_range(0, 199) == 0) re = 1'b0;
      else if (!re && $urandom_range(0, 9) == 0) re = 1'b1;
      if (rl && $urandom_range(0, 14) == 0) rl = 1'b0;
      else if (!rl && $urandom_range(0, 24) == 0) rl = 1'b1;
      step(re, ($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0), rl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
